// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the CPU data port.
// Word-organised RAM with byte-lane alignment on stores (low-justified data
// shifted into place) and right-justified load data. Reads complete after a
// programmable latency; writes complete one cycle after the request.
// Optional feature macro: DMEM_ERR_CHECK_EN adds data_mem_err, which flags
// illegal masks and misaligned half/word writes (such writes are dropped).
module dmem_responder #(
    parameter int DMEM_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_mem_req,
    input  logic [DMEM_WIDTH-1:0] data_mem_addr,
    input  logic [3:0]            data_mem_wmask,
    input  logic [31:0]           data_mem_write,
    output logic [31:0]           data_mem_read,
    output logic                  data_mem_valid,
`ifdef DMEM_ERR_CHECK_EN
    output logic                  data_mem_err,
`endif
    output logic                  data_mem_busy
);

    localparam int AW    = DMEM_WIDTH - 2;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  wordAddr_q, wordAddr_d;
    logic [1:0]     byteOff_q, byteOff_d;
    logic [31:0]    read_q, read_d;
`ifdef DMEM_ERR_CHECK_EN
    logic           err_q, err_d;
    logic [6:0]     maskWide;
    logic           maskIllegal;
    logic           wrError;
`endif

    logic [31:0]    mem [0:DEPTH-1];

    logic [AW-1:0]  reqWordAddr;
    logic [1:0]     reqByteOff;
    logic           reqAccept;
    logic           isWrite;
    logic [3:0]     wrLanes;
    logic [31:0]    wrData;
    logic           wrEn;
    logic [AW-1:0]  rdWordAddr;
    logic [1:0]     rdByteOff;
    logic [31:0]    rdShifted;

    assign reqWordAddr = data_mem_addr[DMEM_WIDTH-1:2];
    assign reqByteOff  = data_mem_addr[1:0];
    assign reqAccept   = (state_q == IDLE) && data_mem_req;
    assign isWrite     = (data_mem_wmask != 4'b0000);

    // Store alignment: shift mask and data up into their byte lanes; lanes pushed past lane 3 fall off.
    always_comb begin
        wrLanes = data_mem_wmask << reqByteOff;
        wrData  = data_mem_write << {reqByteOff, 3'b000};
`ifdef DMEM_ERR_CHECK_EN
        maskWide    = {3'b000, data_mem_wmask} << reqByteOff;
        maskIllegal = !((data_mem_wmask == 4'b0001) || (data_mem_wmask == 4'b0011) ||
                        (data_mem_wmask == 4'b1111));
        wrError     = maskIllegal || (maskWide[6:4] != 3'b000);
        wrEn        = reqAccept && isWrite && !wrError;
`else
        wrEn        = reqAccept && isWrite;
`endif
    end

    // Read path: the IDLE address is used directly for single-cycle reads, otherwise the latched one.
    always_comb begin
        rdWordAddr = (state_q == IDLE) ? reqWordAddr : wordAddr_q;
        rdByteOff  = (state_q == IDLE) ? reqByteOff  : byteOff_q;
        rdShifted  = mem[rdWordAddr] >> {rdByteOff, 3'b000};
    end

    // RAM lane writes at the request edge; suppressed while reset is held so an aborted store leaves no trace.
    always_ff @(posedge clk) begin
        if (reset && wrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (wrLanes[b]) begin
                    mem[reqWordAddr][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

    // State register plus latched address, latency counter and held load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wordAddr_q <= '0;
            byteOff_q  <= 2'b00;
            read_q     <= 32'h0;
`ifdef DMEM_ERR_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wordAddr_q <= wordAddr_d;
            byteOff_q  <= byteOff_d;
            read_q     <= read_d;
`ifdef DMEM_ERR_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next-state logic: requests are only looked at in IDLE; load data is captured on the edge entering RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wordAddr_d = wordAddr_q;
        byteOff_d  = byteOff_q;
        read_d     = read_q;
`ifdef DMEM_ERR_CHECK_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_mem_req) begin
                    if (isWrite) begin
                        state_d = RESP;
`ifdef DMEM_ERR_CHECK_EN
                        err_d   = wrError;
`endif
                    end else begin
                        wordAddr_d = reqWordAddr;
                        byteOff_d  = reqByteOff;
`ifdef DMEM_ERR_CHECK_EN
                        err_d      = 1'b0;
`endif
                        if (READ_LATENCY == 1) begin
                            state_d = RESP;
                            read_d  = rdShifted;
                        end else begin
                            cnt_d   = 4'(READ_LATENCY - 1);
                            state_d = READ_WAIT;
                        end
                    end
                end
            end
            READ_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    read_d  = rdShifted;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so reset drops valid and busy immediately.
    always_comb begin
        data_mem_valid = (state_q == RESP);
        data_mem_busy  = (state_q != IDLE);
        data_mem_read  = read_q;
`ifdef DMEM_ERR_CHECK_EN
        data_mem_err   = (state_q == RESP) && err_q;
`endif
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed sequence with a scoreboard queue of
// expected load data, checked with immediate assertions. A second instance
// runs with READ_LATENCY=1 for the back-to-back spacing check.
module tb_dmem_responder;

    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req, req1;
    logic [DW-1:0] addr, addr1;
    logic [3:0]    wmask, wmask1;
    logic [31:0]   wdata, wdata1;
    logic [31:0]   rdata, rdata1;
    logic          valid, valid1;
    logic          busy, busy1;
`ifdef DMEM_ERR_CHECK_EN
    logic          err, err1;
    logic          expErrQ[$];
`endif

    int            vectors = 0;
    int            miscompares = 0;
    logic [31:0]   expQ[$];
    logic [31:0]   model[int];
    logic [31:0]   lastRead;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    dmem_responder #(.DMEM_WIDTH(DW), .READ_LATENCY(LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_mem_req   (req),
        .data_mem_addr  (addr),
        .data_mem_wmask (wmask),
        .data_mem_write (wdata),
        .data_mem_read  (rdata),
        .data_mem_valid (valid),
`ifdef DMEM_ERR_CHECK_EN
        .data_mem_err   (err),
`endif
        .data_mem_busy  (busy)
    );

    dmem_responder #(.DMEM_WIDTH(DW), .READ_LATENCY(1)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .data_mem_req   (req1),
        .data_mem_addr  (addr1),
        .data_mem_wmask (wmask1),
        .data_mem_write (wdata1),
        .data_mem_read  (rdata1),
        .data_mem_valid (valid1),
`ifdef DMEM_ERR_CHECK_EN
        .data_mem_err   (err1),
`endif
        .data_mem_busy  (busy1)
    );

    // Reference load: word lookup then right-justify by the byte offset.
    function automatic logic [31:0] modelRead(input logic [DW-1:0] a);
        int          k;
        logic [31:0] w;
        k = int'(a[DW-1:2]);
        w = model.exists(k) ? model[k] : 32'h0;
        return w >> (8 * int'(a[1:0]));
    endfunction

    // Reference store: place each masked data byte at lane b+offset, dropping lanes past 3.
    function automatic logic modelWrite(input logic [DW-1:0] a, input logic [3:0] m,
                                        input logic [31:0] d);
        int          k;
        int          off;
        logic [31:0] w;
        logic        e;
        k   = int'(a[DW-1:2]);
        off = int'(a[1:0]);
        w   = model.exists(k) ? model[k] : 32'h0;
        e   = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        if (!(m == 4'b0001 || m == 4'b0011 || m == 4'b1111) || ((int'(m) << off) > 15)) begin
            e = 1'b1;
        end
`endif
        if (!e) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b] && (b + off) < 4) begin
                    w[8*(b+off) +: 8] = d[8*b +: 8];
                end
            end
            model[k] = w;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one request for a single cycle and push the expected response.
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [3:0] m,
                                 input logic [31:0] d);
        logic [31:0] e;
        logic        werr;
        @(negedge clk);
        req   = 1'b1;
        addr  = a;
        wmask = m;
        wdata = d;
        if (m == 4'b0000) begin
            e        = modelRead(a);
            lastRead = e;
            expQ.push_back(e);
            werr     = 1'b0;
        end else begin
            werr = modelWrite(a, m, d);
            expQ.push_back(lastRead);
        end
`ifdef DMEM_ERR_CHECK_EN
        expErrQ.push_back(werr);
`endif
        @(negedge clk);
        req   = 1'b0;
        wmask = 4'b0000;
    endtask

    // Wait (bounded) for the valid pulse, compare against the scoreboard, then confirm the pulse is one cycle.
    task automatic completeAccess(input string tag, input int expLat);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, 32'(n), 32'(expLat));
        if (valid === 1'b1 && expQ.size() > 0) begin
            checkOutput({tag, " data"}, rdata, expQ.pop_front());
`ifdef DMEM_ERR_CHECK_EN
            checkOutput({tag, " err"}, {31'b0, err}, {31'b0, expErrQ.pop_front()});
`endif
        end else begin
            expQ.delete();
`ifdef DMEM_ERR_CHECK_EN
            expErrQ.delete();
`endif
        end
        @(negedge clk);
        checkOutput({tag, " single pulse"}, {31'b0, valid}, 32'h0);
    endtask

    // Safety net in case a wait outside completeAccess never resolves.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        reset    = 1'b0;
        req      = 1'b0;
        addr     = '0;
        wmask    = 4'b0000;
        wdata    = 32'h0;
        req1     = 1'b0;
        addr1    = '0;
        wmask1   = 4'b0000;
        wdata1   = 32'h0;
        lastRead = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("reset valid", {31'b0, valid}, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        checkOutput("reset read", rdata, 32'h0);
        reset = 1'b1;

        applyStimulus(16'h0010, 4'b1111, 32'hDEADBEEF);
        completeAccess("wr word", 0);
        applyStimulus(16'h0010, 4'b0000, 32'h0);
        checkOutput("rd busy in wait", {31'b0, busy}, 32'h1);
        checkOutput("rd early valid", {31'b0, valid}, 32'h0);
        completeAccess("rd word", LAT - 1);

        applyStimulus(16'h0020, 4'b1111, 32'h11223344);
        completeAccess("wr base", 0);
        applyStimulus(16'h0023, 4'b0001, 32'h000000AB);
        completeAccess("wr byte3", 0);
        applyStimulus(16'h0023, 4'b0000, 32'h0);
        completeAccess("rd byte3", LAT - 1);
        applyStimulus(16'h0022, 4'b0000, 32'h0);
        completeAccess("rd half2", LAT - 1);
        applyStimulus(16'h0020, 4'b0000, 32'h0);
        completeAccess("rd merged", LAT - 1);

        applyStimulus(16'h0010, 4'b0000, 32'h0);
        req   = 1'b1;
        addr  = 16'h0020;
        wmask = 4'b1111;
        wdata = 32'h55555555;
        @(negedge clk);
        req   = 1'b0;
        wmask = 4'b0000;
        checkOutput("ign valid", {31'b0, valid}, 32'h1);
        checkOutput("ign data", rdata, expQ.pop_front());
`ifdef DMEM_ERR_CHECK_EN
        void'(expErrQ.pop_front());
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("ign no extra pulse", {31'b0, valid}, 32'h0);
        end
        applyStimulus(16'h0020, 4'b0000, 32'h0);
        completeAccess("ign word intact", LAT - 1);

        applyStimulus(16'h0010, 4'b0000, 32'h0);
        checkOutput("abort busy before", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("abort valid", {31'b0, valid}, 32'h0);
        checkOutput("abort busy", {31'b0, busy}, 32'h0);
        checkOutput("abort read", rdata, 32'h0);
        expQ.delete();
`ifdef DMEM_ERR_CHECK_EN
        expErrQ.delete();
`endif
        lastRead = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abort no pulse", {31'b0, valid}, 32'h0);
        end
        applyStimulus(16'h0010, 4'b0000, 32'h0);
        completeAccess("reread", LAT - 1);

        applyStimulus(16'h0013, 4'b0011, 32'h00001234);
        completeAccess("mis half", 0);
        applyStimulus(16'h0010, 4'b0000, 32'h0);
        completeAccess("mis result", LAT - 1);

        @(negedge clk);
        req1   = 1'b1;
        addr1  = 16'h0040;
        wmask1 = 4'b1111;
        wdata1 = 32'hCAFEF00D;
        @(negedge clk);
        req1   = 1'b0;
        wmask1 = 4'b0000;
        checkOutput("l1 wr valid", {31'b0, valid1}, 32'h1);
        @(negedge clk);
        checkOutput("l1 wr pulse end", {31'b0, valid1}, 32'h0);
        req1  = 1'b1;
        addr1 = 16'h0042;
        @(negedge clk);
        req1  = 1'b0;
        checkOutput("l1 rd1 valid", {31'b0, valid1}, 32'h1);
        checkOutput("l1 rd1 data", rdata1, 32'h0000CAFE);
        @(negedge clk);
        checkOutput("l1 gap", {31'b0, valid1}, 32'h0);
        req1  = 1'b1;
        addr1 = 16'h0040;
        @(negedge clk);
        req1  = 1'b0;
        checkOutput("l1 rd2 valid", {31'b0, valid1}, 32'h1);
        checkOutput("l1 rd2 data", rdata1, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("l1 rd2 pulse end", {31'b0, valid1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
